// File: rtl/issue_queue_entry_allocator_pkg.sv
// Shared scheduler types for the issue-queue free-list manager.
// Default widths for dispatch/issue lanes and the issue-queue index space.
package issue_queue_entry_allocator_pkg;

  localparam int ISSUE_QUEUE_ENTRY_NUM   = 16;
  localparam int ISSUE_QUEUE_INDEX_WIDTH = $clog2(ISSUE_QUEUE_ENTRY_NUM);
  localparam int DISPATCH_WIDTH          = 2;
  localparam int ISSUE_WIDTH             = 2;

  typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0] IssueQueueIndexPath;
  typedef logic [ISSUE_QUEUE_INDEX_WIDTH:0]   IssueQueueCountPath;

endpackage

// File: rtl/issue_queue_entry_allocator_if.sv
// Dispatch/release/status bundle between the scheduler pipeline and the IQ free list.
// The master side is the pipeline; the slave side is the allocator.
interface issue_queue_entry_allocator_if
  import issue_queue_entry_allocator_pkg::*;
#(
  parameter int INDEX_WIDTH   = ISSUE_QUEUE_INDEX_WIDTH,
  parameter int ALLOC_WIDTH   = DISPATCH_WIDTH,
  parameter int RELEASE_WIDTH = ISSUE_WIDTH
);
  logic                                   flush;
  logic                                   stall;
  logic [ALLOC_WIDTH-1:0]                 allocReq;
  logic [ALLOC_WIDTH*INDEX_WIDTH-1:0]     allocPtr;
  logic                                   allocGrant;
  logic [RELEASE_WIDTH-1:0]               releaseEntry;
  logic [RELEASE_WIDTH*INDEX_WIDTH-1:0]   releasePtr;
  logic [INDEX_WIDTH:0]                   freeCount;
  logic                                   allEmpty;
  logic                                   overflowErr;

  modport master (
    output flush, stall, allocReq, releaseEntry, releasePtr,
    input  allocPtr, allocGrant, freeCount, allEmpty, overflowErr
  );

  modport slave (
    input  flush, stall, allocReq, releaseEntry, releasePtr,
    output allocPtr, allocGrant, freeCount, allEmpty, overflowErr
  );
endinterface

// File: rtl/issue_queue_entry_allocator_lane_rank.sv
// Prefix popcount over a lane request vector: each lane's rank is the number of
// active lanes below it; total is the popcount of the whole vector.
module iq_lane_rank #(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            req,
  output logic [WIDTH-1:0][CNT_W-1:0] rank,
  output logic [CNT_W-1:0]            total
);
  logic [CNT_W-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int k = 0; k < WIDTH; k++) begin
      rank[k] = acc;
      acc     = acc + CNT_W'(req[k]);
    end
    total = acc;
  end
endmodule

// File: rtl/issue_queue_entry_allocator.sv
// Circular free list of issue-queue indices: grants up to ALLOC_WIDTH indices per
// cycle to dispatch and reclaims up to RELEASE_WIDTH indices per cycle from wakeup.
module issue_queue_entry_allocator
  import issue_queue_entry_allocator_pkg::*;
#(
  parameter int ENTRY_NUM     = ISSUE_QUEUE_ENTRY_NUM,
  parameter int INDEX_WIDTH   = $clog2(ENTRY_NUM),
  parameter int ALLOC_WIDTH   = DISPATCH_WIDTH,
  parameter int RELEASE_WIDTH = ISSUE_WIDTH
) (
  input logic                          clk,
  input logic                          rst,
  issue_queue_entry_allocator_if.slave iq
);
  localparam int ALLOC_CNT_W = $clog2(ALLOC_WIDTH + 1);
  localparam int REL_CNT_W   = $clog2(RELEASE_WIDTH + 1);

  typedef logic [INDEX_WIDTH-1:0] indexT;
  typedef logic [INDEX_WIDTH:0]   countT;
  typedef logic [INDEX_WIDTH+1:0] sumT;

  indexT list [ENTRY_NUM];
  indexT head;
  indexT tail;
  countT count;
  logic  overflowErrR;

  logic [ALLOC_WIDTH-1:0][ALLOC_CNT_W-1:0] allocRank;
  logic [ALLOC_CNT_W-1:0]                  allocTotal;
  logic [RELEASE_WIDTH-1:0][REL_CNT_W-1:0] relRank;
  logic [REL_CNT_W-1:0]                    relTotal;

  logic                               grant;
  countT                              allocNum;
  countT                              relNum;
  sumT                                countSum;
  logic                               overflowNow;
  logic [ALLOC_WIDTH*INDEX_WIDTH-1:0] allocPtrFlat;
  logic [ENTRY_NUM-1:0]               isFree;

  iq_lane_rank #(.WIDTH(ALLOC_WIDTH), .CNT_W(ALLOC_CNT_W)) u_allocRank (
    .req   (iq.allocReq),
    .rank  (allocRank),
    .total (allocTotal)
  );

  iq_lane_rank #(.WIDTH(RELEASE_WIDTH), .CNT_W(REL_CNT_W)) u_relRank (
    .req   (iq.releaseEntry),
    .rank  (relRank),
    .total (relTotal)
  );

  // All-or-nothing grant; requesting lanes read consecutive list slots from head.
  always_comb begin
    grant        = !iq.stall && !iq.flush && (countT'(allocTotal) <= count);
    allocNum     = grant ? countT'(allocTotal) : '0;
    relNum       = countT'(relTotal);
    countSum     = sumT'(count) - sumT'(allocNum) + sumT'(relNum);
    overflowNow  = countSum > sumT'(ENTRY_NUM);
    allocPtrFlat = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (iq.allocReq[k]) begin
        allocPtrFlat[k*INDEX_WIDTH +: INDEX_WIDTH] = list[head + indexT'(allocRank[k])];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        list[i] <= indexT'(i);
      end
      head  <= '0;
      tail  <= '0;
      count <= countT'(ENTRY_NUM);
      if (rst) begin
        overflowErrR <= 1'b0;
      end
    end else begin
      head <= head + indexT'(allocNum);
      for (int k = 0; k < RELEASE_WIDTH; k++) begin
        if (iq.releaseEntry[k]) begin
          list[tail + indexT'(relRank[k])] <= iq.releasePtr[k*INDEX_WIDTH +: INDEX_WIDTH];
        end
      end
      tail <= tail + indexT'(relNum);
      if (overflowNow) begin
        overflowErrR <= 1'b1;
        count        <= countT'(ENTRY_NUM);
      end else begin
        count <= countT'(countSum);
      end
    end
  end

  assign iq.allocPtr    = allocPtrFlat;
  assign iq.allocGrant  = grant;
  assign iq.freeCount   = count;
  assign iq.allEmpty    = (count == countT'(ENTRY_NUM));
  assign iq.overflowErr = overflowErrR;

  // Membership of the free window [head, head+count), used only for the double-free check.
  always_comb begin
    isFree = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (countT'(i) < count) begin
        isFree[list[head + indexT'(i)]] = 1'b1;
      end
    end
  end

  // An overflowing release is already reported through overflowErr, so it is not re-flagged here.
  always @(posedge clk) begin
    for (int k = 0; k < RELEASE_WIDTH; k++) begin
      if (!rst && !iq.flush && !overflowNow && !overflowErrR && iq.releaseEntry[k]) begin
        assert (!isFree[iq.releasePtr[k*INDEX_WIDTH +: INDEX_WIDTH]])
          else $error("issue_queue_entry_allocator: lane %0d released free index %0d",
                      k, iq.releasePtr[k*INDEX_WIDTH +: INDEX_WIDTH]);
      end
    end
  end
endmodule
